// File: rtl/obi_core_port_arbiter.sv
// Round-robin arbiter that folds NUM_PORTS OBI managers onto one OBI manager port.
// Issued port indices are queued in order so each response returns to its originator.
module obi_core_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  sbr_req_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       sbr_addr_i,
  input  logic [NUM_PORTS-1:0]                  sbr_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]     sbr_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       sbr_wdata_i,
  output logic [NUM_PORTS-1:0]                  sbr_gnt_o,
  output logic [NUM_PORTS-1:0]                  sbr_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 sbr_rdata_o,
  output logic                                  mgr_req_o,
  output logic [ADDR_WIDTH-1:0]                 mgr_addr_o,
  output logic                                  mgr_we_o,
  output logic [DATA_WIDTH/8-1:0]               mgr_be_o,
  output logic [DATA_WIDTH-1:0]                 mgr_wdata_o,
  input  logic                                  mgr_gnt_i,
  input  logic                                  mgr_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 mgr_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  protocol_err_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PORTS - 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] held_q, held_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             full;
  logic             empty;
  logic             issue;
  logic             hs;
  logic             pop;
  int               k;

  always_comb begin
    sel   = rr_ptr_q;
    cand  = rr_ptr_q;
    found = 1'b0;
    k     = 0;
    if (lock_q) begin
      sel = held_q;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        k = int'(rr_ptr_q) + i;
        if (k >= NUM_PORTS) k = k - NUM_PORTS;
        cand = IDX_W'(k);
        if (!found && sbr_req_i[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end

    full  = (count_q == CNT_MAX);
    empty = (count_q == '0);
    // Full blocks issue regardless of a same-cycle pop: keeps rvalid off the req path.
    issue = sbr_req_i[sel] & ~full;
    hs    = issue & mgr_gnt_i;
    pop   = mgr_rvalid_i & ~empty;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    held_d   = held_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (!full) begin
      if (lock_q && !sbr_req_i[held_q]) begin
        lock_d = 1'b0;
        err_d  = 1'b1;
      end else if (hs) begin
        lock_d = 1'b0;
      end else if (issue) begin
        lock_d = 1'b1;
        held_d = sel;
      end
    end

    if (hs) begin
      rr_ptr_d         = (sel == IDX_LAST) ? '0 : sel + 1'b1;
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    if (mgr_rvalid_i && empty) err_d = 1'b1;

    case ({hs, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      held_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      held_q   <= held_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
    end
  end

  // Every output is forced low while reset is held.
  always_comb begin
    mgr_req_o      = 1'b0;
    mgr_addr_o     = '0;
    mgr_we_o       = 1'b0;
    mgr_be_o       = '0;
    mgr_wdata_o    = '0;
    sbr_gnt_o      = '0;
    sbr_rvalid_o   = '0;
    sbr_rdata_o    = '0;
    outstanding_o  = '0;
    protocol_err_o = 1'b0;
    if (!rst_i) begin
      mgr_req_o = issue;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (sel == IDX_W'(p)) begin
          mgr_addr_o  = sbr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
          mgr_we_o    = sbr_we_i[p];
          mgr_be_o    = sbr_be_i[p*BE_W +: BE_W];
          mgr_wdata_o = sbr_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (hs) sbr_gnt_o[sel] = 1'b1;
      if (pop) sbr_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
      sbr_rdata_o    = mgr_rdata_i;
      outstanding_o  = count_q;
      protocol_err_o = err_q;
    end
  end

endmodule

// File: tb/tb_obi_core_port_arbiter.sv
// Directed bench for obi_core_port_arbiter: fairness, lock, full, push/pop, errors, reset.
module tb_obi_core_port_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req;
  logic [NP*AW-1:0]  addr;
  logic [NP-1:0]     we;
  logic [NP*BW-1:0]  be;
  logic [NP*DW-1:0]  wdata;
  logic [NP-1:0]     gnt_o;
  logic [NP-1:0]     rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              mreq;
  logic [AW-1:0]     maddr;
  logic              mwe;
  logic [BW-1:0]     mbe;
  logic [DW-1:0]     mwdata;
  logic              mgnt;
  logic              mrvalid;
  logic [DW-1:0]     mrdata;
  logic [CW-1:0]     outstanding;
  logic              perr;

  int total = 0;
  int bad   = 0;

  obi_core_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .sbr_req_i(req), .sbr_addr_i(addr), .sbr_we_i(we), .sbr_be_i(be), .sbr_wdata_i(wdata),
    .sbr_gnt_o(gnt_o), .sbr_rvalid_o(rvalid_o), .sbr_rdata_o(rdata_o),
    .mgr_req_o(mreq), .mgr_addr_o(maddr), .mgr_we_o(mwe), .mgr_be_o(mbe), .mgr_wdata_o(mwdata),
    .mgr_gnt_i(mgnt), .mgr_rvalid_i(mrvalid), .mgr_rdata_i(mrdata),
    .outstanding_o(outstanding), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic g, input logic v);
    req     = r;
    mgnt    = g;
    mrvalid = v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b1);
    cyc();
    drive(2'b11, 1'b1, 1'b1);
    total++; if (mreq !== 1'b0) begin bad++; $display("FAIL rst_mreq got=%b want=0", mreq); end
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b want=00", gnt_o); end
    total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b want=00", rvalid_o); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rst_outst got=%0d want=0", outstanding); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", perr); end
    cyc();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0);
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL post_rst_outst got=%0d want=0", outstanding); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL post_rst_err got=%b want=0", perr); end
  endtask

  task automatic test_fairness();
    logic [1:0] rin [5];
    logic       gin [5];
    logic       vin [5];
    logic [1:0] eg  [5];
    logic [1:0] erv [5];
    rin = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    gin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vin = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    eg  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    erv = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      cyc();
      mrdata = 32'hD000_0000 + i;
      drive(rin[i], gin[i], vin[i]);
      total++; if (gnt_o !== eg[i]) begin bad++; $display("FAIL fair_gnt[%0d] got=%b want=%b", i, gnt_o, eg[i]); end
      total++; if (rvalid_o !== erv[i]) begin bad++; $display("FAIL fair_rvalid[%0d] got=%b want=%b", i, rvalid_o, erv[i]); end
      total++; if (rdata_o !== 32'hD000_0000 + i) begin bad++; $display("FAIL fair_rdata[%0d] got=%h want=%h", i, rdata_o, 32'hD000_0000 + i); end
    end
    cyc();
    drive(2'b00, 1'b0, 1'b0);
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL fair_outst got=%0d want=0", outstanding); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL fair_err got=%b want=0", perr); end
  endtask

  task automatic test_lock();
    logic [1:0]  rin [8];
    logic        gin [8];
    logic        vin [8];
    logic [1:0]  eg  [8];
    logic [1:0]  erv [8];
    logic [31:0] ea  [8];
    rin = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    gin = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vin = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    eg  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    erv = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    ea  = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h2000, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      cyc();
      drive(rin[i], gin[i], vin[i]);
      total++; if (gnt_o !== eg[i]) begin bad++; $display("FAIL lock_gnt[%0d] got=%b want=%b", i, gnt_o, eg[i]); end
      total++; if (rvalid_o !== erv[i]) begin bad++; $display("FAIL lock_rvalid[%0d] got=%b want=%b", i, rvalid_o, erv[i]); end
      if (i < 6) begin
        total++; if (mreq !== 1'b1) begin bad++; $display("FAIL lock_mreq[%0d] got=%b want=1", i, mreq); end
        total++; if (maddr !== ea[i]) begin bad++; $display("FAIL lock_addr[%0d] got=%h want=%h", i, maddr, ea[i]); end
      end
      if (i >= 1 && i <= 4) begin
        total++;
        if (mwe !== 1'b1 || mbe !== 4'hF || mwdata !== 32'hA5A5_0000) begin
          bad++; $display("FAIL lock_payload[%0d] got=%b/%h/%h want=1/f/a5a50000", i, mwe, mbe, mwdata);
        end
      end
    end
    cyc();
    drive(2'b00, 1'b0, 1'b0);
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL lock_outst got=%0d want=0", outstanding); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(2'b01, 1'b1, 1'b0);
      total++; if (outstanding !== CW'(i)) begin bad++; $display("FAIL full_fill_outst[%0d] got=%0d want=%0d", i, outstanding, i); end
      total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL full_fill_gnt[%0d] got=%b want=01", i, gnt_o); end
    end
    cyc();
    drive(2'b01, 1'b1, 1'b1);
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_outst got=%0d want=4", outstanding); end
    total++; if (mreq !== 1'b0) begin bad++; $display("FAIL full_mreq got=%b want=0", mreq); end
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL full_gnt got=%b want=00", gnt_o); end
    total++; if (rvalid_o !== 2'b01) begin bad++; $display("FAIL full_rvalid got=%b want=01", rvalid_o); end
    cyc();
    drive(2'b01, 1'b1, 1'b0);
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL full_after_pop_outst got=%0d want=3", outstanding); end
    total++; if (mreq !== 1'b1) begin bad++; $display("FAIL full_reassert_mreq got=%b want=1", mreq); end
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL full_reassert_gnt got=%b want=01", gnt_o); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(2'b00, 1'b0, 1'b1);
      total++; if (rvalid_o !== 2'b01) begin bad++; $display("FAIL full_drain[%0d] got=%b want=01", i, rvalid_o); end
    end
    cyc();
    drive(2'b00, 1'b0, 1'b0);
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL full_end_outst got=%0d want=0", outstanding); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL full_err got=%b want=0", perr); end
  endtask

  task automatic test_push_pop();
    cyc();
    drive(2'b10, 1'b1, 1'b0);
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL pp_setup0 got=%b want=10", gnt_o); end
    cyc();
    drive(2'b01, 1'b1, 1'b0);
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL pp_setup1 got=%b want=01", gnt_o); end
    cyc();
    drive(2'b11, 1'b1, 1'b1);
    total++; if (outstanding !== 3'd2) begin bad++; $display("FAIL pp_pre_outst got=%0d want=2", outstanding); end
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL pp_gnt got=%b want=10", gnt_o); end
    total++; if (rvalid_o !== 2'b10) begin bad++; $display("FAIL pp_rvalid got=%b want=10", rvalid_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    total++; if (outstanding !== 3'd2) begin bad++; $display("FAIL pp_post_outst got=%0d want=2", outstanding); end
    total++; if (rvalid_o !== 2'b01) begin bad++; $display("FAIL pp_drain0 got=%b want=01", rvalid_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    total++; if (rvalid_o !== 2'b10) begin bad++; $display("FAIL pp_drain1 got=%b want=10", rvalid_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b0);
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL pp_end_outst got=%0d want=0", outstanding); end
  endtask

  task automatic test_spurious();
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL spur_rvalid got=%b want=00", rvalid_o); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL spur_err_before got=%b want=0", perr); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(2'b00, 1'b0, 1'b0);
      total++; if (perr !== 1'b1) begin bad++; $display("FAIL spur_err_sticky[%0d] got=%b want=1", i, perr); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(2'b01, 1'b1, 1'b0);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b0);
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL rmid_pre_outst got=%0d want=3", outstanding); end
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b1);
    total++; if (mreq !== 1'b0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00 || perr !== 1'b0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL rmid_in_rst got=%b/%b/%b/%b/%0d want=0/00/00/0/0", mreq, gnt_o, rvalid_o, perr, outstanding);
    end
    cyc();
    drive(2'b11, 1'b1, 1'b1);
    total++; if (mreq !== 1'b0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00 || perr !== 1'b0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL rmid_rst2 got=%b/%b/%b/%b/%0d want=0/00/00/0/0", mreq, gnt_o, rvalid_o, perr, outstanding);
    end
    cyc();
    rst = 1'b0;
    drive(2'b11, 1'b1, 1'b0);
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rmid_outst got=%0d want=0", outstanding); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b want=0", perr); end
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL rmid_rrptr_gnt got=%b want=01", gnt_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    total++; if (rvalid_o !== 2'b01) begin bad++; $display("FAIL rmid_rvalid got=%b want=01", rvalid_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL rmid_stale_rvalid got=%b want=00", rvalid_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b0);
    total++; if (perr !== 1'b1) begin bad++; $display("FAIL rmid_stale_err got=%b want=1", perr); end
  endtask

  task automatic test_lock_drop();
    cyc();
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    drive(2'b01, 1'b0, 1'b0);
    total++; if (mreq !== 1'b1 || gnt_o !== 2'b00) begin bad++; $display("FAIL drop_stall got=%b/%b want=1/00", mreq, gnt_o); end
    cyc();
    drive(2'b10, 1'b0, 1'b0);
    total++; if (mreq !== 1'b0) begin bad++; $display("FAIL drop_mreq got=%b want=0", mreq); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL drop_err_before got=%b want=0", perr); end
    cyc();
    drive(2'b10, 1'b1, 1'b0);
    total++; if (perr !== 1'b1) begin bad++; $display("FAIL drop_err got=%b want=1", perr); end
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL drop_released_gnt got=%b want=10", gnt_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b1);
    total++; if (rvalid_o !== 2'b10) begin bad++; $display("FAIL drop_rvalid got=%b want=10", rvalid_o); end
    cyc();
    drive(2'b00, 1'b0, 1'b0);
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL drop_outst got=%0d want=0", outstanding); end
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    mgnt    = 1'b0;
    mrvalid = 1'b0;
    mrdata  = '0;
    addr    = {32'h0000_2000, 32'h0000_1000};
    we      = 2'b01;
    be      = {4'h3, 4'hF};
    wdata   = {32'h5A5A_0000, 32'hA5A5_0000};
    test_reset();
    test_fairness();
    test_lock();
    test_full();
    test_push_pop();
    test_spurious();
    test_reset_mid();
    test_lock_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_core_port_arbiter.md
Name: obi_core_port_arbiter

Overview:
- Parametrised successor to the single-core CPU memory wiring in the CPU subsystem.
- Multiplexes NUM_PORTS OBI manager ports onto one OBI manager port toward the bus:
  - Upstream sources: instr/data ports of several harts, or a core plus a debug/accelerator manager.
  - Arbitration: round-robin, with a stable-request lock.
  - Outstanding transactions are tracked in order, so each rvalid returns to its originating port.
- Sits between the core instances and the system bus crossbar.

Parameters:
NUM_PORTS, 2, number of upstream OBI managers (>=2)
ADDR_WIDTH, 32, OBI address width
DATA_WIDTH, 32, OBI data width; byte enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, maximum issued-but-unanswered transactions (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
sbr_req_i  in  NUM_PORTS  per-port request
sbr_addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address, port p at slice p
sbr_we_i  in  NUM_PORTS  per-port write enable
sbr_be_i  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables
sbr_wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data
sbr_gnt_o  out  NUM_PORTS  per-port grant
sbr_rvalid_o  out  NUM_PORTS  per-port response valid
sbr_rdata_o  out  DATA_WIDTH  response data, broadcast to all ports
mgr_req_o  out  1  downstream request
mgr_addr_o  out  ADDR_WIDTH  downstream address
mgr_we_o  out  1  downstream write enable
mgr_be_o  out  DATA_WIDTH/8  downstream byte enables
mgr_wdata_o  out  DATA_WIDTH  downstream write data
mgr_gnt_i  in  1  downstream grant
mgr_rvalid_i  in  1  downstream response valid
mgr_rdata_i  in  DATA_WIDTH  downstream response data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
protocol_err_o  out  1  sticky protocol-violation flag

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous and active-high.
- State:
  - rr_ptr, reset 0.
  - lock flag, reset 0, and held index.
  - Response-route FIFO of port indices, depth MAX_OUTSTANDING, reset empty; count reset 0.
  - protocol_err_o, reset 0.
- Outputs while rst_i is high: all outputs 0, including mgr_req_o, sbr_gnt_o and sbr_rvalid_o.
- Selection (combinational):
  - If locked, sel = held index.
  - Otherwise sel = first requesting port at or after rr_ptr, searching upward and wrapping modulo NUM_PORTS.
- Request issue:
  - mgr_req_o = sbr_req_i[sel] & (count != MAX_OUTSTANDING).
  - mgr_addr/we/be/wdata are driven from port sel; their values are don't-care when mgr_req_o=0.
- Grant: sbr_gnt_o[sel] = mgr_req_o & mgr_gnt_i, same cycle (zero latency); all other grant bits are 0.
- Handshake (mgr_req_o & mgr_gnt_i):
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) wraps to 0 at NUM_PORTS.
  - lock <= 0.
- Stall (mgr_req_o & !mgr_gnt_i): lock <= 1, held <= sel. The address and port stay stable until grant, as OBI requires.
- Full: when count == MAX_OUTSTANDING, mgr_req_o = 0 even if mgr_rvalid_i pops in the same cycle. This keeps rvalid off the combinational request path. The lock state is unchanged while full.
- Response:
  - On mgr_rvalid_i with a non-empty FIFO, sbr_rvalid_o[head] = 1 in the same cycle, and the head is popped.
  - sbr_rdata_o = mgr_rdata_i at all times.
- Simultaneous push and pop: count unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- Errors (each sets protocol_err_o; it stays set until reset):
  - mgr_rvalid_i while the FIFO is empty: response dropped, no sbr_rvalid_o.
  - Locked port deasserting sbr_req_i before grant: lock released.
- Reset mid-transaction: all tracking is discarded. Responses arriving after reset set protocol_err_o, because the FIFO is empty.
- outstanding_o = count, registered.

Test Plan:
- Fairness: NUM_PORTS=2, both ports request continuously, mgr_gnt_i=1 every cycle -> grants alternate 0,1,0,1; rvalid returns to ports in the same order.
- Lock: port 0 requests at addr 0x1000 and mgr_gnt_i is held 0 for 3 cycles while port 1 requests -> mgr_addr_o stays 0x1000 for all 3 cycles; port 1 is granted only after port 0.
- Full: MAX_OUTSTANDING=4, 4 grants issued with no rvalid -> outstanding_o=4 and mgr_req_o=0. One rvalid -> mgr_req_o reasserts the next cycle.
- Same-cycle push and pop: count=2, grant and rvalid in the same cycle -> outstanding_o stays 2; rvalid is routed to the oldest port.
- Spurious response: mgr_rvalid_i with count=0 -> no sbr_rvalid_o; protocol_err_o=1 until rst_i.
- Reset mid-operation: rst_i asserted with 3 outstanding -> next cycle outstanding_o=0, rr_ptr=0, and all outputs 0.
